qdec_counter: RTL and testbench

QDEC_COUNTER -- requirements
Module: qdec_counter

---
 rtl/qdec_counter.sv | 179 +++++++++++++++++
 tb/tb_qdec_counter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qdec_counter.sv
// Quadrature decoder with input synchronizers, run-length filters, a 4x
// position counter, an optional index zeroing mechanism and sticky flags.
module qdec_counter #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned FILTER_LEN    = 2,
  parameter int unsigned ZERO_ON_INDEX = 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             quad_a,
  input  logic             quad_b,
  input  logic             index,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             err_clr,
  output logic [WIDTH-1:0] qd,
  output logic             dir,
  output logic             err,
  output logic             idx_seen
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned INIT_W = 5;
  localparam int unsigned NCH    = 3;
  localparam logic [CNT_W-1:0]  RUN_LAST  = CNT_W'(FILTER_LEN - 1);
  // INIT lasts as long as the sync+filter pipeline, so a level held
  // through reset reaches prev_ab before tracking starts.
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(FILTER_LEN + 2);

  typedef enum logic {
    ST_INIT,
    ST_TRACK
  } state_t;

  // Channel order: [2] index, [1] A, [0] B
  logic [NCH-1:0]   sync1;
  logic [NCH-1:0]   sync2;
  logic [NCH-1:0]   filt;
  logic [CNT_W-1:0] run [NCH];

  state_t            state, state_n;
  logic [INIT_W-1:0] init_cnt, init_cnt_n;
  logic [1:0]        prev_ab, prev_ab_n;
  logic              idx_prev, idx_prev_n;
  logic [WIDTH-1:0]  qd_n;
  logic              dir_n, err_n, idx_seen_n;

  logic [1:0] filt_ab;
  logic [1:0] pos_cur, pos_prev, delta;
  logic       step_up, step_dn, illegal, idx_rise;

  assign filt_ab = filt[1:0];

  // Map Gray-coded AB onto a 2-bit position so a step is a +/-1 difference.
  function automatic logic [1:0] ab_to_pos(input logic [1:0] ab);
    logic [1:0] p;
    case (ab)
      2'b00:   p = 2'd0;
      2'b01:   p = 2'd1;
      2'b11:   p = 2'd2;
      default: p = 2'd3;
    endcase
    return p;
  endfunction

  // Two-flop synchronizers for the asynchronous encoder pins.
  always_ff @(posedge clk) begin
    if (!clear) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {index, quad_a, quad_b};
      sync2 <= sync1;
    end
  end

  // Run-length filters: accept a new level after FILTER_LEN differing cycles.
  always_ff @(posedge clk) begin
    if (!clear) begin
      filt <= '0;
      for (int i = 0; i < NCH; i++) run[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (sync2[i] != filt[i]) begin
          if (run[i] == RUN_LAST) begin
            filt[i] <= sync2[i];
            run[i]  <= '0;
          end else begin
            run[i] <= run[i] + CNT_W'(1);
          end
        end else begin
          run[i] <= '0;
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!clear) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      prev_ab  <= '0;
      idx_prev <= 1'b0;
      qd       <= '0;
      dir      <= 1'b0;
      err      <= 1'b0;
      idx_seen <= 1'b0;
    end else begin
      state    <= state_n;
      init_cnt <= init_cnt_n;
      prev_ab  <= prev_ab_n;
      idx_prev <= idx_prev_n;
      qd       <= qd_n;
      dir      <= dir_n;
      err      <= err_n;
      idx_seen <= idx_seen_n;
    end
  end

  // Next-state, step decode and next output values.
  always_comb begin
    state_n    = state;
    init_cnt_n = init_cnt;
    prev_ab_n  = filt_ab;
    idx_prev_n = filt[2];
    qd_n       = qd;
    dir_n      = dir;
    err_n      = err;
    idx_seen_n = idx_seen;
    pos_cur    = ab_to_pos(filt_ab);
    pos_prev   = ab_to_pos(prev_ab);
    delta      = pos_cur - pos_prev;
    step_up    = 1'b0;
    step_dn    = 1'b0;
    illegal    = 1'b0;
    idx_rise   = 1'b0;

    case (state)
      ST_INIT: begin
        if (init_cnt == INIT_LAST) begin
          state_n = ST_TRACK;
        end else begin
          init_cnt_n = init_cnt + INIT_W'(1);
        end
        if (load) qd_n = d;
        if (err_clr) err_n = 1'b0;
      end
      ST_TRACK: begin
        step_up  = (delta == 2'd1);
        step_dn  = (delta == 2'd3);
        illegal  = (delta == 2'd2);
        idx_rise = filt[2] & ~idx_prev;
        if (idx_rise) idx_seen_n = 1'b1;
        if (load) begin
          qd_n = d;
        end else if (idx_rise && (ZERO_ON_INDEX != 0)) begin
          qd_n = '0;
        end else if (step_up) begin
          qd_n = qd + WIDTH'(1);
        end else if (step_dn) begin
          qd_n = qd - WIDTH'(1);
        end
        if (step_up) begin
          dir_n = 1'b1;
        end else if (step_dn) begin
          dir_n = 1'b0;
        end
        if (illegal) begin
          err_n = 1'b1;
        end else if (err_clr) begin
          err_n = 1'b0;
        end
      end
      default: state_n = ST_INIT;
    endcase
  end

endmodule

// File: tb/tb_qdec_counter.sv
// Directed bench for qdec_counter: scoreboard of expected outputs.
module tb_qdec_counter;

  logic       clk;
  logic       clear;
  logic       quad_a, quad_b, index;
  logic       load;
  logic [7:0] d;
  logic       err_clr;
  logic [7:0] qd;
  logic       dir, err, idx_seen;

  typedef struct packed {
    logic [7:0] qd;
    logic       dir;
    logic       err;
    logic       idx;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  logic [7:0] m_qd;
  logic       m_dir, m_err, m_idx;
  logic [1:0] cur_ab;

  qdec_counter #(.WIDTH(8), .FILTER_LEN(2), .ZERO_ON_INDEX(1)) dut (
    .clk      (clk),
    .clear    (clear),
    .quad_a   (quad_a),
    .quad_b   (quad_b),
    .index    (index),
    .load     (load),
    .d        (d),
    .err_clr  (err_clr),
    .qd       (qd),
    .dir      (dir),
    .err      (err),
    .idx_seen (idx_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ab(input logic [1:0] ab);
    quad_a = ab[1];
    quad_b = ab[0];
  endtask

  function automatic logic [1:0] next_fwd(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] next_rev(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic push_model();
    exp_t e;
    e.qd  = m_qd;
    e.dir = m_dir;
    e.err = m_err;
    e.idx = m_idx;
    sb.push_back(e);
  endtask

  task automatic check_pop(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    checks++;
    assert (qd === e.qd) else begin
      failures++;
      $error("FAIL %s qd observed=%0h expected=%0h", tag, qd, e.qd);
    end
    checks++;
    assert (dir === e.dir) else begin
      failures++;
      $error("FAIL %s dir observed=%0b expected=%0b", tag, dir, e.dir);
    end
    checks++;
    assert (err === e.err) else begin
      failures++;
      $error("FAIL %s err observed=%0b expected=%0b", tag, err, e.err);
    end
    checks++;
    assert (idx_seen === e.idx) else begin
      failures++;
      $error("FAIL %s idx_seen observed=%0b expected=%0b", tag, idx_seen, e.idx);
    end
  endtask

  task automatic step_fwd(input string tag);
    cur_ab = next_fwd(cur_ab);
    set_ab(cur_ab);
    m_qd  = m_qd + 8'd1;
    m_dir = 1'b1;
    push_model();
    tick(8);
    check_pop(tag);
  endtask

  task automatic step_rev(input string tag);
    cur_ab = next_rev(cur_ab);
    set_ab(cur_ab);
    m_qd  = m_qd - 8'd1;
    m_dir = 1'b0;
    push_model();
    tick(8);
    check_pop(tag);
  endtask

  task automatic do_load(input logic [7:0] val, input string tag);
    d    = val;
    load = 1'b1;
    tick(1);
    load = 1'b0;
    m_qd = val;
    push_model();
    tick(1);
    check_pop(tag);
  endtask

  initial begin
    clear   = 1'b0;
    index   = 1'b0;
    load    = 1'b0;
    d       = 8'h00;
    err_clr = 1'b0;
    cur_ab  = 2'b11;
    set_ab(cur_ab);
    m_qd = 8'h00; m_dir = 1'b0; m_err = 1'b0; m_idx = 1'b0;

    // Reset with AB=11 held, then release
    tick(3);
    push_model();
    check_pop("reset");
    clear = 1'b1;
    tick(10);
    push_model();
    check_pop("release_ab11");

    // Reset mid-run; AB=01 level after release must be absorbed
    cur_ab = 2'b01;
    set_ab(cur_ab);
    tick(3);
    clear = 1'b0;
    tick(2);
    clear = 1'b1;
    tick(10);
    push_model();
    check_pop("mid_reset");

    // 16 forward then 16 reverse transitions
    for (int i = 0; i < 16; i++) step_fwd($sformatf("fwd%0d", i));
    for (int i = 0; i < 16; i++) step_rev($sformatf("rev%0d", i));

    // Load and wrap upward
    do_load(8'hFE, "load_fe");
    for (int i = 0; i < 3; i++) step_fwd($sformatf("wrap_up%0d", i));

    // Wrap downward from zero
    do_load(8'h00, "load_00");
    step_rev("wrap_dn");

    // One-cycle glitch on A is filtered out
    quad_a = ~quad_a;
    tick(1);
    quad_a = cur_ab[1];
    tick(8);
    push_model();
    check_pop("glitch");

    // Both phases change at once -> sticky error, count held
    cur_ab = ~cur_ab;
    set_ab(cur_ab);
    m_err = 1'b1;
    push_model();
    tick(8);
    check_pop("illegal");
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    m_err = 1'b0;
    push_model();
    tick(1);
    check_pop("err_clr");

    // Index edge together with a forward step zeroes the count
    cur_ab = next_fwd(cur_ab);
    set_ab(cur_ab);
    index = 1'b1;
    m_qd = 8'h00; m_dir = 1'b1; m_idx = 1'b1;
    push_model();
    tick(8);
    check_pop("index_zero");
    index = 1'b0;
    tick(8);

    // Load wins over index zero and step in the same cycle
    cur_ab = next_fwd(cur_ab);
    set_ab(cur_ab);
    index = 1'b1;
    d = 8'h40;
    tick(4);
    load = 1'b1;
    tick(1);
    load = 1'b0;
    m_qd = 8'h40; m_dir = 1'b1;
    push_model();
    tick(3);
    check_pop("load_index");
    index = 1'b0;
    tick(8);

    // Latency: no update after 4 edges, update on the 5th
    cur_ab = next_fwd(cur_ab);
    set_ab(cur_ab);
    push_model();
    tick(4);
    check_pop("lat_4");
    m_qd = m_qd + 8'd1;
    push_model();
    tick(1);
    check_pop("lat_5");

    // Clear wins over load and err_clr
    clear   = 1'b0;
    load    = 1'b1;
    d       = 8'hAA;
    err_clr = 1'b1;
    tick(1);
    m_qd = 8'h00; m_dir = 1'b0; m_err = 1'b0; m_idx = 1'b0;
    push_model();
    check_pop("clear_prio");
    load    = 1'b0;
    err_clr = 1'b0;
    clear   = 1'b1;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
